voice_scheduler: RTL
====================

Name: voice_scheduler

Overview:
Sequencer that time-shares one registered sine ROM among up to 4 note voices. On each sample request it reads the ROM once per active voice, sums the results with scaling, and presents one mixed 16-bit sample. It sits between the song-reader/notes-player control path and the codec sample interface. It replaces having one ROM per voice.

Parameters:
PHASE_W, 22, phase accumulator width per voice
ADDR_W, 10, sine ROM address width (top ADDR_W bits of phase)
ROM_LAT, 1, cycles from rom_rd to rom_data valid (1..3)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
play_enable  in  1  1 = run; 0 = hold all state, ignore sample requests
load_new_note  in  1  1-cycle pulse: latch steps/num_notes, clear phases
num_notes  in  2  active voices minus 1 (0 -> 1 voice, 3 -> 4 voices)
steps  in  4*PHASE_W  per-voice phase increment; voice v at [v*PHASE_W +: PHASE_W]
metadata  in  3  bit0 = harmonic enable (used only with the optional feature)
generate_next_sample  in  1  request one mixed sample
rom_rd  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM address
rom_data  in  16  signed ROM output, valid ROM_LAT cycles after rom_rd
sample_out  out  16  signed mixed sample, held between updates
new_sample_ready  out  1  1-cycle pulse when sample_out updates
busy  out  1  1 while a sequence is in flight
overrun  out  1  1-cycle pulse when a request is dropped because busy

Behaviour:
- Reset (reset = 0, async): all outputs 0, phases 0, latched steps 0, nv = 1, state IDLE.
- States and transitions:
  - IDLE -> ISSUE when generate_next_sample & play_enable & !load_new_note.
  - ISSUE: issues one read per cycle for voices 0..nv-1, then goes to DRAIN.
  - DRAIN: waits until all nv reads have returned, then goes to OUTPUT.
  - OUTPUT: lasts 1 cycle, then returns to IDLE.
- Timing: request sampled at edge 0. rom_rd is high in cycles 1..nv with rom_addr = phase[v][PHASE_W-1 -: ADDR_W]. Data is captured ROM_LAT cycles after each strobe. new_sample_ready and the sample_out update occur in cycle nv+ROM_LAT+1. busy is high from cycle 1 through the new_sample_ready cycle.
- Phase update: phase[v] <= phase[v] + step[v] (mod 2^PHASE_W) in the cycle voice v is issued. The update uses the pre-increment phase for the address. Inactive voices keep phase 0.
- Arithmetic:
  - Each rom_data is sign-extended to 18 bits and added to an accumulator that is cleared at ISSUE entry.
  - sample_out = acc >>> s, with s = 0, 1, 2, 2 for nv = 1, 2, 3, 4.
  - Overflow is impossible; there is no saturation.
- load_new_note:
  - Takes effect in every state: latches steps and num_notes, clears all phases, aborts any in-flight sequence.
  - On abort: no new_sample_ready, sample_out keeps its old value, state goes to IDLE. ROM data still in flight is discarded.
  - If it coincides with generate_next_sample, load wins, the request is dropped, and no overrun pulse is generated.
- generate_next_sample while busy: ignored, overrun pulses for 1 cycle, the sequence is unaffected.
- play_enable = 0: an in-flight sequence completes normally. New requests are ignored without overrun. Phases and sample_out hold.
- Async reset mid-sequence: immediate return to reset state; no partial output.

Optional Feature:
Macro HARMONICS_EN.
- Defined, with metadata[0] = 1:
  - Each voice issues a second read at (2*phase)[PHASE_W-1 -: ADDR_W] in the cycle after its fundamental read, so there are 2*nv strobes.
  - The harmonic data is added to the accumulator as rom_data >>> 1.
  - The accumulator widens to 19 bits and s increases by 1.
  - Latency becomes 2*nv+ROM_LAT+1.
- Defined, with metadata[0] = 0: behaviour is identical to the base block.
- Not defined: metadata is ignored and its logic is absent; base behaviour only.

Test Plan:
Bench ROM model: ROM_LAT = 1, rom_data = {6'b0, addr}.
1. Reset low mid-ISSUE with nv = 4 -> all outputs 0 immediately. After release, 1 voice with step = 0x1000 plus 3 requests -> sample_out = 0, 1, 2 (addr increments by 1 per sample), each ready at cycle 3.
2. nv = 4, steps 0x1000, 0x2000, 0x3000, 0x4000; 2 requests -> first sample 0. Second sample: (1+2+3+4) >>> 2 = 2. rom_rd high for 4 consecutive cycles; new_sample_ready at cycle 6.
3. Request repeated at cycle 2 of a 4-voice sequence -> overrun pulses once; exactly one new_sample_ready.
4. load_new_note at cycle 3 of a sequence -> no new_sample_ready, sample_out unchanged, busy low next cycle. Next request restarts from phase 0 with the new steps.
5. play_enable = 0 with requests every 4 cycles for 40 cycles -> no rom_rd, no overrun, sample_out and phases unchanged.
6. HARMONICS_EN with metadata[0] = 1, nv = 1, phase addr 3 -> reads at addr 3 then addr 6; sample_out = (3 + (6 >>> 1)) >>> 1 = 3; ready at cycle 4.

Source files
------------

// File: rtl/voice_scheduler.sv
// Time-shares one registered sine ROM among up to 4 voices and mixes one sample per request.
// Optional HARMONICS_EN adds a half-amplitude second-harmonic read per voice (metadata[0]).
module voice_scheduler #(
   parameter int PHASE_W = 22,
   parameter int ADDR_W  = 10,
   parameter int ROM_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   play_enable,
   input  logic                   load_new_note,
   input  logic [1:0]             num_notes,
   input  logic [4*PHASE_W-1:0]   steps,
   input  logic [2:0]             metadata,
   input  logic                   generate_next_sample,
   output logic                   rom_rd,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic [15:0]            rom_data,
   output logic [15:0]            sample_out,
   output logic                   new_sample_ready,
   output logic                   busy,
   output logic                   overrun
);

`ifdef HARMONICS_EN
   localparam int ACC_W = 19;
`else
   localparam int ACC_W = 18;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;

   state_t                     r_state, w_state_nxt;
   logic [PHASE_W-1:0]         r_phase [4];
   logic [PHASE_W-1:0]         r_step  [4];
   logic [1:0]                 r_nv_m1;
   logic [2:0]                 r_issue_idx;
   logic [2:0]                 r_ret_cnt;
   logic [ROM_LAT-1:0]         r_vld_pipe;
   logic [ROM_LAT-1:0]         r_hrm_pipe;
   logic signed [ACC_W-1:0]    r_acc;
   logic [15:0]                r_sample;
   logic                       r_overrun;

   logic                       w_harm;
   logic                       w_start;
   logic                       w_rd;
   logic [2:0]                 w_last_idx;
   logic [1:0]                 w_voice;
   logic                       w_is_harm_slot;
   logic                       w_voice_done;
   logic                       w_cap;
   logic                       w_cap_hrm;
   logic                       w_ret_last;
   logic signed [ACC_W-1:0]    w_term;
   logic signed [ACC_W-1:0]    w_acc_sum;
   logic                       w_unused_meta;

`ifdef HARMONICS_EN
   logic r_harm;
   assign w_harm        = r_harm;
   assign w_unused_meta = ^metadata[2:1];
`else
   assign w_harm        = 1'b0;
   assign w_unused_meta = ^metadata;
`endif

   // Mix scaling: 1,2,3,4 voices shift by 0,1,2,2; harmonic mode adds one more.
   function automatic logic [15:0] scale_mix(input logic signed [ACC_W-1:0] acc,
                                             input logic [1:0] nv_m1,
                                             input logic harm);
      logic [2:0] s;
      s = (nv_m1 == 2'd0) ? 3'd0 : (nv_m1 == 2'd1) ? 3'd1 : 3'd2;
      s = s + {2'b0, harm};
      return 16'(acc >>> s);
   endfunction

   assign w_start        = (r_state == S_IDLE) && generate_next_sample && play_enable && !load_new_note;
   assign w_rd           = (r_state == S_ISSUE);
   assign w_last_idx     = w_harm ? {r_nv_m1, 1'b1} : {1'b0, r_nv_m1};
   assign w_voice        = w_harm ? r_issue_idx[2:1] : r_issue_idx[1:0];
   assign w_is_harm_slot = w_harm & r_issue_idx[0];
   // Phase advances after a voice's last read so the harmonic read sees the same phase.
   assign w_voice_done   = !w_harm | r_issue_idx[0];
   assign w_cap          = r_vld_pipe[ROM_LAT-1];
   assign w_cap_hrm      = r_hrm_pipe[ROM_LAT-1];
   assign w_ret_last     = w_cap && (r_ret_cnt == w_last_idx);

   assign w_term = w_cap_hrm ? {{(ACC_W-15){rom_data[15]}}, rom_data[15:1]}
                             : {{(ACC_W-16){rom_data[15]}}, rom_data};
   assign w_acc_sum = r_acc + w_term;

   assign rom_rd           = w_rd;
   assign rom_addr         = !w_rd          ? '0 :
                             w_is_harm_slot ? r_phase[w_voice][PHASE_W-2 -: ADDR_W] :
                                              r_phase[w_voice][PHASE_W-1 -: ADDR_W];
   assign sample_out       = r_sample;
   assign new_sample_ready = (r_state == S_OUTPUT);
   assign busy             = (r_state != S_IDLE);
   assign overrun          = r_overrun;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_state_nxt = S_ISSUE;
         S_ISSUE:  if (r_issue_idx == w_last_idx) w_state_nxt = S_DRAIN;
         S_DRAIN:  if (w_ret_last) w_state_nxt = S_OUTPUT;
         S_OUTPUT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
      if (load_new_note) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_nv_m1     <= 2'd0;
         r_issue_idx <= 3'd0;
         r_ret_cnt   <= 3'd0;
         r_vld_pipe  <= '0;
         r_hrm_pipe  <= '0;
         r_acc       <= '0;
         r_sample    <= 16'd0;
         r_overrun   <= 1'b0;
`ifdef HARMONICS_EN
         r_harm      <= 1'b0;
`endif
         for (int v = 0; v < 4; v++) begin
            r_phase[v] <= '0;
            r_step[v]  <= '0;
         end
      end else begin
         r_state   <= w_state_nxt;
         r_overrun <= generate_next_sample && play_enable && busy && !load_new_note;
         if (load_new_note) begin
            // Abort: drop in-flight ROM returns; sample_out keeps its last value.
            r_nv_m1     <= num_notes;
            r_issue_idx <= 3'd0;
            r_ret_cnt   <= 3'd0;
            r_vld_pipe  <= '0;
            r_hrm_pipe  <= '0;
            for (int v = 0; v < 4; v++) begin
               r_phase[v] <= '0;
               r_step[v]  <= steps[v*PHASE_W +: PHASE_W];
            end
         end else begin
            r_vld_pipe[0] <= w_rd;
            r_hrm_pipe[0] <= w_rd & w_is_harm_slot;
            for (int i = 1; i < ROM_LAT; i++) begin
               r_vld_pipe[i] <= r_vld_pipe[i-1];
               r_hrm_pipe[i] <= r_hrm_pipe[i-1];
            end
            if (w_start) begin
               r_acc       <= '0;
               r_issue_idx <= 3'd0;
               r_ret_cnt   <= 3'd0;
`ifdef HARMONICS_EN
               r_harm      <= metadata[0];
`endif
            end
            if (w_rd) begin
               r_issue_idx <= r_issue_idx + 3'd1;
               if (w_voice_done) r_phase[w_voice] <= r_phase[w_voice] + r_step[w_voice];
            end
            if (w_cap) begin
               r_acc     <= w_acc_sum;
               r_ret_cnt <= r_ret_cnt + 3'd1;
               if (w_ret_last) r_sample <= scale_mix(w_acc_sum, r_nv_m1, w_harm);
            end
         end
      end
   end

endmodule
